// File: rtl/byte_aligner_if.sv
// Byte stream and status bundle between the deserializer side and the aligner.
interface byte_aligner_if;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [2:0] bit_offset;
    logic       align_err;

    // Source of raw bytes, consumer of aligned payload and status
    modport master (
        output data_in,
        input  data_out,
        input  data_valid,
        input  locked,
        input  bit_offset,
        input  align_err
    );

    // The aligner itself
    modport slave (
        input  data_in,
        output data_out,
        output data_valid,
        output locked,
        output bit_offset,
        output align_err
    );
endinterface

// File: rtl/byte_aligner.sv
// Byte/frame aligner: hunts for the sync byte at every bit offset, confirms it
// over several frames, then emits re-aligned payload bytes until repeated sync
// misses force a new hunt.
//
// state | meaning
// HUNT  | search all 8 offsets for the sync byte
// CHECK | offset candidate found, confirming sync at each frame start
// LOCK  | offset locked, payload bytes emitted, sync misses counted
module byte_aligner #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         FRAME_LEN  = 5,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 4
) (
    input  logic          div_8_clk,
    input  logic          rst_n,
    byte_aligner_if.slave bus
);

    localparam logic [3:0] POS_LAST   = 4'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_q;
    logic [3:0] pos_q, pos_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic [2:0] offset_q, offset_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [15:0] window;
    logic [7:0]  cand [8];
    logic [7:0]  hit_vec;
    logic        any_hit;
    logic [2:0]  hit_k;
    logic [7:0]  cur_byte;
    logic        sync_ok;
    logic [3:0]  pos_next;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // The earliest received bit sits at window[15]; offset k drops k leading bits.
    assign window = {prev_q, bus.data_in};

    for (genvar k = 0; k < 8; k++) begin : g_cand
        assign cand[k]    = window[15-k : 8-k];
        assign hit_vec[k] = (cand[k] == SYNC_BYTE);
    end

    assign cur_byte = cand[offset_q];
    assign sync_ok  = (cur_byte == SYNC_BYTE);
    assign pos_next = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;

    // Lowest matching offset wins when several offsets hit at once
    always_comb begin
        any_hit = |hit_vec;
        hit_k   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_k = 3'(k);
            end
        end
    end

    // Next-state, counters and registered-output decisions
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        offset_d    = offset_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            HUNT: begin
                if (any_hit) begin
                    offset_d    = hit_k;
                    pos_d       = 4'd1;
                    match_cnt_d = 4'd1;
                    if (LOCK_CNT == 1) begin
                        state_d    = LOCK;
                        miss_cnt_d = 4'd0;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                pos_d = pos_next;
                if (pos_q == 4'd0) begin
                    if (sync_ok) begin
                        match_cnt_d = sat_inc(match_cnt_q);
                        if (sat_inc(match_cnt_q) == LOCK_TGT) begin
                            state_d    = LOCK;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
            end

            LOCK: begin
                pos_d = pos_next;
                if (pos_q != 4'd0) begin
                    data_out_d = cur_byte;
                    valid_d    = 1'b1;
                end else if (sync_ok) begin
                    miss_cnt_d = 4'd0;
                end else begin
                    err_d      = 1'b1;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (sat_inc(miss_cnt_q) == UNLOCK_TGT) begin
                        state_d = HUNT;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= 8'd0;
            pos_q       <= 4'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            offset_q    <= 3'd0;
            data_out_q  <= 8'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= bus.data_in;
            pos_q       <= pos_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            offset_q    <= offset_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.locked     = (state_q == LOCK);
    assign bus.bit_offset = offset_q;
    assign bus.align_err  = err_q;

endmodule

// File: tb/tb_byte_aligner.sv
// Directed bench for byte_aligner with a bit-window reference model.
module tb_byte_aligner;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int FL = 5;
    localparam int LC = 3;
    localparam int UC = 4;

    logic clk;
    logic rst_n;

    byte_aligner_if bus ();

    byte_aligner #(
        .SYNC_BYTE  (SYNC),
        .FRAME_LEN  (FL),
        .LOCK_CNT   (LC),
        .UNLOCK_CNT (UC)
    ) dut (
        .div_8_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 searching, 1 confirming, 2 tracking
    int         m_mode   = 0;
    int         m_phase  = 0;
    int         m_hits   = 0;
    int         m_misses = 0;
    int         m_found;
    int         m_ph;
    logic       m_good;
    logic [2:0] m_off    = 3'd0;
    logic [7:0] m_prev   = 8'd0;
    logic [7:0] m_data   = 8'd0;
    logic [7:0] m_b;
    logic       m_valid  = 1'b0;
    logic       m_err    = 1'b0;

    // Byte that starts k bits into the older of two consecutive bytes
    function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b, input int k);
        logic [15:0] w;
        w = {a, b};
        w = w << k;
        w = w >> 8;
        return w[7:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_hits = 0; m_misses = 0;
            m_off = 3'd0; m_prev = 8'd0; m_data = 8'd0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_b = bus.data_in;
            m_valid = 1'b0;
            m_err = 1'b0;
            if (m_mode == 0) begin
                m_found = -1;
                for (int k = 7; k >= 0; k--)
                    if (pick(m_prev, m_b, k) == SYNC) m_found = k;
                if (m_found >= 0) begin
                    m_off = 3'(m_found);
                    m_phase = 1;
                    m_hits = 1;
                    m_misses = 0;
                    m_mode = (LC == 1) ? 2 : 1;
                end
            end else begin
                m_ph = m_phase;
                m_phase = (m_phase + 1) % FL;
                m_good = (pick(m_prev, m_b, int'(m_off)) == SYNC);
                if (m_mode == 1) begin
                    if (m_ph == 0) begin
                        if (m_good) begin
                            m_hits++;
                            if (m_hits >= LC) begin m_mode = 2; m_misses = 0; end
                        end else begin
                            m_mode = 0;
                        end
                    end
                end else begin
                    if (m_ph != 0) begin
                        m_valid = 1'b1;
                        m_data = pick(m_prev, m_b, int'(m_off));
                    end else if (m_good) begin
                        m_misses = 0;
                    end else begin
                        m_err = 1'b1;
                        m_misses++;
                        if (m_misses >= UC) m_mode = 0;
                    end
                end
            end
            m_prev = m_b;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("cyc_data_valid", bus.data_valid, m_valid);
        chk("cyc_data_out",   bus.data_out,   m_data);
        chk("cyc_locked",     bus.locked,     (m_mode == 2));
        chk("cyc_bit_offset", bus.bit_offset, m_off);
        chk("cyc_align_err",  bus.align_err,  m_err);
    end

    // ---------------- observation counters ----------------
    int         cnt_valid  = 0;
    int         cnt_err    = 0;
    int         cnt_locked = 0;
    logic [7:0] vq [$];

    always @(posedge clk) begin
        #1;
        if (bus.data_valid) begin
            cnt_valid++;
            vq.push_back(bus.data_out);
        end
        if (bus.align_err) cnt_err++;
        if (bus.locked) cnt_locked++;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] sh_last;

    task automatic step(input logic [7:0] b);
        bus.data_in = b;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] s);
        step(s); step(8'h11); step(8'h22); step(8'h33); step(8'h44);
    endtask

    // Serial stream delayed by 3 bits before byte packing
    task automatic sstep(input logic [7:0] b);
        logic [15:0] t;
        t = {sh_last, b};
        t = t >> 3;
        sh_last = b;
        step(t[7:0]);
    endtask

    task automatic sframe(input logic [7:0] s);
        sstep(s); sstep(8'h11); sstep(8'h22); sstep(8'h33); sstep(8'h44);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.data_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sh_last = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ns [4];
    logic [7:0] exp_pl [4];
    int v0, e0, l0;

    initial begin
        ns = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
        exp_pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b0;
        bus.data_in = 8'h00;
        sh_last = 8'h00;

        // 1: reset with random input, then a stream with no sync at any offset
        repeat (4) begin
            bus.data_in = 8'($urandom);
            @(negedge clk);
        end
        chk("rst_valid",  bus.data_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_data",   bus.data_out, 0);
        chk("rst_offset", bus.bit_offset, 0);
        chk("rst_err",    bus.align_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(ns[i % 4]);
        chk("nosync_locked_cycles", cnt_locked, 0);
        chk("nosync_valid_cycles",  cnt_valid, 0);

        // 2: aligned stream, k=0
        do_reset();
        vq.delete();
        frame(SYNC); frame(SYNC); step(SYNC);
        chk("k0_prelock", bus.locked, 0);
        step(8'h11);
        chk("k0_lock", bus.locked, 1);
        step(8'h22); step(8'h33); step(8'h44);
        v0 = cnt_valid;
        frame(SYNC); frame(SYNC);
        chk("k0_valid_per_2frames", cnt_valid - v0, 8);
        chk("k0_offset", bus.bit_offset, 0);
        chk("k0_payload_count_ok", (vq.size() >= 4), 1);
        for (int i = 0; i < 4; i++)
            if (i < vq.size()) chk("k0_payload", vq[i], exp_pl[i]);

        // 4: sync corruption in lock
        e0 = cnt_err; v0 = cnt_valid; l0 = cnt_locked;
        frame(8'h00);
        chk("miss1_err_pulses", cnt_err - e0, 1);
        chk("miss1_valid",      cnt_valid - v0, 4);
        chk("miss1_locked",     cnt_locked - l0, 5);
        frame(SYNC);
        e0 = cnt_err;
        frame(8'h00); frame(8'h00); frame(8'h00); step(8'h00);
        chk("miss4_still_locked", bus.locked, 1);
        step(8'h11);
        chk("miss4_unlocked", bus.locked, 0);
        chk("miss4_err_now",  bus.align_err, 1);
        chk("miss4_err_pulses", cnt_err - e0, 4);
        step(8'h22); step(8'h33); step(8'h44);
        frame(SYNC); frame(SYNC); step(SYNC);
        chk("relock_pre", bus.locked, 0);
        step(8'h11);
        chk("relock", bus.locked, 1);
        step(8'h22); step(8'h33); step(8'h44);

        // 6: asynchronous reset mid-payload
        step(SYNC); step(8'h11); step(8'h22);
        chk("arst_pre_valid", bus.data_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", bus.locked, 0);
        chk("arst_valid",  bus.data_valid, 0);
        chk("arst_data",   bus.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(SYNC); frame(SYNC); step(SYNC);
        chk("arst_relock_pre", bus.locked, 0);
        step(8'h11);
        chk("arst_relock", bus.locked, 1);
        step(8'h22); step(8'h33); step(8'h44);

        // 5: confirm failure returns to hunting
        do_reset();
        v0 = cnt_valid;
        frame(SYNC); frame(8'hFF);
        chk("chkfail_locked", bus.locked, 0);
        chk("chkfail_valid",  cnt_valid - v0, 0);
        frame(SYNC); frame(SYNC); step(SYNC);
        chk("chkfail_relock_pre", bus.locked, 0);
        step(8'h11);
        chk("chkfail_relock", bus.locked, 1);
        step(8'h22); step(8'h33); step(8'h44);

        // 3: stream shifted by 3 bits
        do_reset();
        vq.delete();
        sframe(SYNC); sframe(SYNC); sstep(SYNC);
        chk("k3_prelock", bus.locked, 0);
        sstep(8'h11);
        chk("k3_lock",   bus.locked, 1);
        chk("k3_offset", bus.bit_offset, 3);
        sstep(8'h22); sstep(8'h33); sstep(8'h44);
        sframe(SYNC); sstep(SYNC);
        chk("k3_payload_count", vq.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < vq.size()) chk("k3_payload", vq[i], exp_pl[i % 4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/byte_aligner.md
# byte_aligner

Byte and frame aligner between `deserializer` and `eight_to_thirty_two`, clocked by `div_8_clk`. The deserializer delivers bytes with an arbitrary, unknown bit offset. This block does three things:
- hunts for a sync byte at all 8 bit offsets;
- confirms the hit over several frames, then locks the offset;
- outputs re-aligned payload bytes with a valid strobe.

It drops out of lock after repeated sync misses, so `eight_to_thirty_two` always receives word-aligned payload.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame sync pattern.
- `FRAME_LEN`, 5: bytes per frame (1 sync + 4 payload); legal range 2..16.
- `LOCK_CNT`, 3: consecutive sync matches required to lock; range 1..15.
- `UNLOCK_CNT`, 4: consecutive sync misses in lock that force re-hunt; range 1..15.

Ports:
- `div_8_clk`, in, 1: the single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset. Driven from `rst_sync_o`.
- `data_in`, in, 8: raw byte from `deserializer`. Bit 7 is the earliest bit received.
- `data_out`, out, 8: aligned payload byte.
- `data_valid`, out, 1: `data_out` holds a payload byte this cycle.
- `locked`, out, 1: the block is in the LOCK state.
- `bit_offset`, out, 3: the current locked or candidate offset k.
- `align_err`, out, 1: one-cycle pulse on each sync miss while in LOCK.

## Operation
- `prev_q` registers `data_in` every cycle.
- Window W = {`prev_q`, `data_in`} (16 bits). Candidate byte at offset k is C(k) = W[15-k:8-k], for k = 0..7.
- `pos` is the frame position counter, 0..FRAME_LEN-1. Position 0 is the sync byte. The counter wraps from FRAME_LEN-1 to 0 every cycle outside HUNT.
- State machine, encoded {HUNT, CHECK, LOCK}:
  - HUNT: compare all 8 C(k) against SYNC_BYTE each cycle.
    - On any match, take the lowest matching k. Store it in `bit_offset`, set `pos`←1, `match_cnt`←1, go to CHECK. If LOCK_CNT==1, go directly to LOCK instead.
    - With no match, `bit_offset` holds its value.
  - CHECK: only C(`bit_offset`) is evaluated.
    - At `pos`==0, a match increments `match_cnt`. When the incremented value equals LOCK_CNT, go to LOCK with `miss_cnt`←0.
    - A mismatch at `pos`==0 returns to HUNT. Any candidate match on that same cycle is ignored; hunting resumes next cycle.
    - Payload positions are not checked and are not output.
  - LOCK:
    - At `pos`!=0: register C(`bit_offset`) into `data_out` and set `data_valid`=1 the next cycle.
    - At `pos`==0, match: `miss_cnt`←0.
    - At `pos`==0, mismatch: pulse `align_err` and increment `miss_cnt`. When `miss_cnt` reaches UNLOCK_CNT, go to HUNT. Before that, stay in LOCK and keep the offset and frame phase.
    - The sync position never produces `data_valid`, whether it matches or not.
- `data_out` holds its last value when `data_valid`=0.
- Counters saturate; none wraps.

## Timing
- Reset values: state=HUNT. `prev_q`, `data_out`, `bit_offset`, `pos`, `match_cnt` and `miss_cnt` = 0. `data_valid`, `locked` and `align_err` = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release, hunting starts afresh.
- Latency: payload bits completing in `data_in` at cycle n appear on `data_out` with `data_valid` at cycle n+1. For k=0 the byte is `prev_q`, so that is 2 cycles after it first appeared on `data_in`.
- `locked` goes high the cycle after the LOCK_CNT-th sync match, and low the cycle after the UNLOCK_CNT-th consecutive miss.
- `align_err` is high for exactly 1 cycle, coincident with the registered miss decision.
- `data_valid` is never high while `locked`=0.
- In steady-state lock, `data_valid` is high for FRAME_LEN-1 cycles out of every FRAME_LEN.

## Test plan
1. Reset check: hold `rst_n`=0 with random `data_in` → all outputs 0. Release and feed bytes that never contain A5 at any offset → `locked`=0 and `data_valid`=0 indefinitely.
2. Aligned stream, k=0, frames A5 11 22 33 44 repeating → `locked` rises after the 3rd sync. Then `data_valid` is high 4 of every 5 cycles, carrying 11, 22, 33, 44 in order; `bit_offset`=0.
3. Same frames shifted by 3 bits (serial stream delayed 3 bits before byte packing) → `bit_offset`=3, lock after 3 syncs, payload 11, 22, 33, 44 recovered exactly.
4. In lock, corrupt one sync to 8'h00 → single `align_err` pulse, `locked` stays 1, payload uninterrupted. Corrupt 4 consecutive syncs → 4 pulses, `locked` falls after the 4th. Restore syncs → relock after 3 good frames.
5. CHECK failure: one good sync, then a frame whose sync is 8'hFF → return to HUNT with no `data_valid` asserted. Relock only after 3 further consecutive good syncs.
6. Assert `rst_n` for one cycle mid-payload while locked → `locked`, `data_valid` and `data_out` clear immediately. After release, the full 3-sync relock is required.
